vproc_div_seq: RTL

Iterative sequencer for the vector divide unit (UNIT_DIV). It accepts one element-pair per handshake and runs a restoring radix-2 division at the current SEW (8/16/32) for vdiv/vdivu/vrem/vremu. It resolves the RVV divide-by-zero and signed-overflow special cases without iterating. Results come back through a valid/ready output. The block sits between the DIV unit's operand unpacking stage and its result packing stage; the DIV unit's top level instantiates one copy per element lane.

---
 rtl/vproc_div_seq_if.sv | 32 +++
 rtl/vproc_div_seq.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/vproc_div_seq_if.sv
// Handshake bundle between the DIV unit's operand unpacker / result packer and
// one iterative divide sequencer lane.
interface vproc_div_seq_if #(
    parameter int unsigned ID_W = 3
);
    logic            in_valid_i;
    logic            in_ready_o;
    logic [31:0]     dividend_i;
    logic [31:0]     divisor_i;
    logic [1:0]      vsew_i;
    logic            op_i;
    logic            signed_i;
    logic [ID_W-1:0] id_i;
    logic            kill_i;
    logic            res_valid_o;
    logic            res_ready_i;
    logic [31:0]     result_o;
    logic [ID_W-1:0] id_o;
    logic            busy_o;

    modport master (
        output in_valid_i, dividend_i, divisor_i, vsew_i, op_i, signed_i, id_i,
               kill_i, res_ready_i,
        input  in_ready_o, res_valid_o, result_o, id_o, busy_o
    );

    modport slave (
        input  in_valid_i, dividend_i, divisor_i, vsew_i, op_i, signed_i, id_i,
               kill_i, res_ready_i,
        output in_ready_o, res_valid_o, result_o, id_o, busy_o
    );
endinterface

// File: rtl/vproc_div_seq.sv
// Restoring radix-2 divide sequencer for vdiv/vdivu/vrem/vremu at SEW 8/16/32.
// Divide-by-zero and signed overflow resolve in PREP without iterating.
module vproc_div_seq #(
    parameter int unsigned ID_W = 3
) (
    input logic             clk_i,
    input logic             sync_rst_ni,
    vproc_div_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        DONE
    } state_t;

    state_t          state_q, state_d;

    logic [31:0]     a_q, b_q;
    logic [1:0]      sew_q;
    logic            op_q, sgn_q;
    logic [ID_W-1:0] id_q;
    logic [31:0]     abs_b_q;
    logic [31:0]     rem_q, quo_q;
    logic [4:0]      cnt_q;
    logic            neg_q_q, neg_r_q;
    logic [31:0]     result_q;

    logic [31:0]     ext_a, ext_b, abs_a, abs_b;
    logic [31:0]     mask, min_val;
    logic [4:0]      last_cnt;
    logic            is_zero, is_ovf, quo_msb;
    logic [32:0]     rem_sh, trial;
    logic [31:0]     q_fix, r_fix;

    // Operand view at the latched SEW: extension, magnitudes and special-case detection.
    always_comb begin
        ext_a    = a_q;
        ext_b    = b_q;
        mask     = 32'hFFFF_FFFF;
        min_val  = 32'h8000_0000;
        last_cnt = 5'd31;
        quo_msb  = quo_q[31];
        case (sew_q)
            2'b00: begin
                ext_a    = {{24{sgn_q & a_q[7]}}, a_q[7:0]};
                ext_b    = {{24{sgn_q & b_q[7]}}, b_q[7:0]};
                mask     = 32'h0000_00FF;
                min_val  = 32'hFFFF_FF80;
                last_cnt = 5'd7;
                quo_msb  = quo_q[7];
            end
            2'b01: begin
                ext_a    = {{16{sgn_q & a_q[15]}}, a_q[15:0]};
                ext_b    = {{16{sgn_q & b_q[15]}}, b_q[15:0]};
                mask     = 32'h0000_FFFF;
                min_val  = 32'hFFFF_8000;
                last_cnt = 5'd15;
                quo_msb  = quo_q[15];
            end
            default: ;
        endcase
        abs_a   = (sgn_q && ext_a[31]) ? -ext_a : ext_a;
        abs_b   = (sgn_q && ext_b[31]) ? -ext_b : ext_b;
        is_zero = (ext_b == 32'd0);
        is_ovf  = sgn_q && (ext_a == min_val) && (ext_b == 32'hFFFF_FFFF);
    end

    // One restoring step; the partial remainder stays below |divisor|, so bit 32
    // of the 33-bit difference is its sign.
    always_comb begin
        rem_sh = {rem_q, quo_msb};
        trial  = rem_sh - {1'b0, abs_b_q};
        q_fix  = neg_q_q ? -quo_q : quo_q;
        r_fix  = neg_r_q ? -rem_q : rem_q;
    end

    always_ff @(posedge clk_i) begin
        if (!sync_rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.in_valid_i) state_d = PREP;
            PREP: state_d = (is_zero || is_ovf) ? DONE : ITER;
            ITER: if (cnt_q == last_cnt) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: if (bus.res_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.kill_i && (state_q != IDLE)) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!sync_rst_ni) begin
            a_q      <= '0;
            b_q      <= '0;
            sew_q    <= '0;
            op_q     <= 1'b0;
            sgn_q    <= 1'b0;
            id_q     <= '0;
            abs_b_q  <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid_i) begin
                        a_q   <= bus.dividend_i;
                        b_q   <= bus.divisor_i;
                        sew_q <= bus.vsew_i;
                        op_q  <= bus.op_i;
                        sgn_q <= bus.signed_i;
                        id_q  <= bus.id_i;
                    end
                end
                PREP: begin
                    neg_q_q <= sgn_q & (ext_a[31] ^ ext_b[31]);
                    neg_r_q <= sgn_q & ext_a[31];
                    abs_b_q <= abs_b;
                    quo_q   <= abs_a;
                    rem_q   <= '0;
                    cnt_q   <= '0;
                    if (is_zero) begin
                        result_q <= op_q ? (ext_a & mask) : mask;
                    end else if (is_ovf) begin
                        result_q <= op_q ? 32'd0 : (ext_a & mask);
                    end
                end
                ITER: begin
                    rem_q <= trial[32] ? rem_sh[31:0] : trial[31:0];
                    quo_q <= {quo_q[30:0], ~trial[32]};
                    cnt_q <= cnt_q + 5'd1;
                end
                FIX: begin
                    result_q <= op_q ? (r_fix & mask) : (q_fix & mask);
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready_o  = (state_q == IDLE);
    assign bus.res_valid_o = (state_q == DONE);
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.result_o    = result_q;
    assign bus.id_o        = id_q;

endmodule
